// File: rtl/scp_core.sv
// scp_core: single-cycle 32-bit MIPS-subset processor core.
// Fetches from a combinational instruction memory and executes one instruction per clock.
// Data memory is byte-addressed and big-endian; loads pick their bytes from the top of drData.
// Optional feature macro SCP_SHIFT_EN: when defined, sll/srl/sra are built; when undefined,
// those funct codes decode as NOPs and the shifter is omitted.
module scp_core (
  input  logic               clk,
  input  logic               regRst,
  input  logic [31:0]        pcIn,
  input  logic               pcRst,
  output logic [31:0]        iaddr,
  input  logic [31:0]        inst,
  output logic [31:0]        daddr,
  input  logic [31:0]        drData,
  output logic [31:0]        dwData,
  output logic               dWr,
  output logic [1:0]         dSize,
  output logic [4:0]         dRt,
  output logic [4:0]         dRs,
  output logic [4:0]         dRd,
  output logic [4:0]         dRw,
  output logic signed [15:0] dimm16,
  output logic [31:0]        dbusA,
  output logic [31:0]        dbusB,
  output logic [31:0]        dbusW,
  output logic               dregWr,
  output logic               dregDst,
  output logic               djal
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

`ifdef SCP_SHIFT_EN
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
`endif
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b11;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_NOR,
    ALU_SLT,
    ALU_SLTU,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_LUI
  } alu_op_e;

  // Architectural state: PC, a flag marking the first clock after reset, and the register file.
  logic [31:0] pc_q, pc_d;
  logic        started_q, started_d;
  logic [31:0] regs_q [32];

  // Instruction fields
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm_sext, imm_zext;

  // Decoded controls
  logic        reg_wr, reg_dst, is_jal;
  logic        use_imm, zero_ext;
  logic        mem_rd, mem_wr, load_signed;
  logic [1:0]  mem_size;
  logic        br_eq, br_ne, is_jump, is_jr;
  alu_op_e     alu_op;

  // Datapath
  logic [31:0] bus_a, bus_b, alu_b, alu_y;
  logic [31:0] load_data, bus_w;
  logic [31:0] pc_plus4, br_target, jump_target;
  logic [4:0]  rf_waddr;
  logic        rf_we;

  assign opcode   = inst[31:26];
  assign rs       = inst[25:21];
  assign rt       = inst[20:16];
  assign rd       = inst[15:11];
  assign funct    = inst[5:0];
  assign imm_sext = {{16{inst[15]}}, inst[15:0]};
  assign imm_zext = {16'h0000, inst[15:0]};

  // Until the first clock after reset the fetch address follows pcIn directly,
  // so the first instruction comes from whatever pcIn holds at release.
  assign iaddr = started_q ? pc_q : pcIn;

  // Instruction decode into datapath controls; unknown encodings leave every control idle.
  always_comb begin
    reg_wr      = 1'b0;
    reg_dst     = 1'b0;
    is_jal      = 1'b0;
    use_imm     = 1'b0;
    zero_ext    = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    load_signed = 1'b0;
    mem_size    = SZ_WORD;
    br_eq       = 1'b0;
    br_ne       = 1'b0;
    is_jump     = 1'b0;
    is_jr       = 1'b0;
    alu_op      = ALU_ADD;
    case (opcode)
      OP_RTYPE: begin
        reg_dst = 1'b1;
        case (funct)
          FN_ADD, FN_ADDU: begin reg_wr = 1'b1; alu_op = ALU_ADD;  end
          FN_SUB, FN_SUBU: begin reg_wr = 1'b1; alu_op = ALU_SUB;  end
          FN_AND:          begin reg_wr = 1'b1; alu_op = ALU_AND;  end
          FN_OR:           begin reg_wr = 1'b1; alu_op = ALU_OR;   end
          FN_XOR:          begin reg_wr = 1'b1; alu_op = ALU_XOR;  end
          FN_NOR:          begin reg_wr = 1'b1; alu_op = ALU_NOR;  end
          FN_SLT:          begin reg_wr = 1'b1; alu_op = ALU_SLT;  end
          FN_SLTU:         begin reg_wr = 1'b1; alu_op = ALU_SLTU; end
`ifdef SCP_SHIFT_EN
          FN_SLL:          begin reg_wr = 1'b1; alu_op = ALU_SLL;  end
          FN_SRL:          begin reg_wr = 1'b1; alu_op = ALU_SRL;  end
          FN_SRA:          begin reg_wr = 1'b1; alu_op = ALU_SRA;  end
`endif
          FN_JR:           is_jr = 1'b1;
          default:         ;
        endcase
      end
      OP_J:     is_jump = 1'b1;
      OP_JAL:   begin is_jump = 1'b1; is_jal = 1'b1; reg_wr = 1'b1; end
      OP_BEQ:   begin br_eq = 1'b1; alu_op = ALU_SUB; end
      OP_BNE:   begin br_ne = 1'b1; alu_op = ALU_SUB; end
      OP_ADDI, OP_ADDIU: begin reg_wr = 1'b1; use_imm = 1'b1; end
      OP_SLTI:  begin reg_wr = 1'b1; use_imm = 1'b1; alu_op = ALU_SLT;  end
      OP_SLTIU: begin reg_wr = 1'b1; use_imm = 1'b1; alu_op = ALU_SLTU; end
      OP_ANDI:  begin reg_wr = 1'b1; use_imm = 1'b1; zero_ext = 1'b1; alu_op = ALU_AND; end
      OP_ORI:   begin reg_wr = 1'b1; use_imm = 1'b1; zero_ext = 1'b1; alu_op = ALU_OR;  end
      OP_XORI:  begin reg_wr = 1'b1; use_imm = 1'b1; zero_ext = 1'b1; alu_op = ALU_XOR; end
      OP_LUI:   begin reg_wr = 1'b1; use_imm = 1'b1; alu_op = ALU_LUI; end
      OP_LB:    begin reg_wr = 1'b1; use_imm = 1'b1; mem_rd = 1'b1; load_signed = 1'b1; mem_size = SZ_BYTE; end
      OP_LBU:   begin reg_wr = 1'b1; use_imm = 1'b1; mem_rd = 1'b1; mem_size = SZ_BYTE; end
      OP_LH:    begin reg_wr = 1'b1; use_imm = 1'b1; mem_rd = 1'b1; load_signed = 1'b1; mem_size = SZ_HALF; end
      OP_LHU:   begin reg_wr = 1'b1; use_imm = 1'b1; mem_rd = 1'b1; mem_size = SZ_HALF; end
      OP_LW:    begin reg_wr = 1'b1; use_imm = 1'b1; mem_rd = 1'b1; mem_size = SZ_WORD; end
      OP_SB:    begin use_imm = 1'b1; mem_wr = 1'b1; mem_size = SZ_BYTE; end
      OP_SH:    begin use_imm = 1'b1; mem_wr = 1'b1; mem_size = SZ_HALF; end
      OP_SW:    begin use_imm = 1'b1; mem_wr = 1'b1; mem_size = SZ_WORD; end
      default:  ;
    endcase
  end

  // Register file read ports; r0 is hard-wired to zero.
  always_comb begin
    bus_a = (rs == 5'd0) ? 32'h0 : regs_q[rs];
    bus_b = (rt == 5'd0) ? 32'h0 : regs_q[rt];
  end

  // ALU: second operand is either rt or the extended immediate; shifts use shamt on rt.
  always_comb begin
    alu_b = use_imm ? (zero_ext ? imm_zext : imm_sext) : bus_b;
    case (alu_op)
      ALU_ADD:  alu_y = bus_a + alu_b;
      ALU_SUB:  alu_y = bus_a - alu_b;
      ALU_AND:  alu_y = bus_a & alu_b;
      ALU_OR:   alu_y = bus_a | alu_b;
      ALU_XOR:  alu_y = bus_a ^ alu_b;
      ALU_NOR:  alu_y = ~(bus_a | alu_b);
      ALU_SLT:  alu_y = {31'h0, ($signed(bus_a) < $signed(alu_b))};
      ALU_SLTU: alu_y = {31'h0, (bus_a < alu_b)};
      ALU_LUI:  alu_y = {inst[15:0], 16'h0000};
`ifdef SCP_SHIFT_EN
      ALU_SLL:  alu_y = alu_b << inst[10:6];
      ALU_SRL:  alu_y = alu_b >> inst[10:6];
      ALU_SRA:  alu_y = $unsigned($signed(alu_b) >>> inst[10:6]);
`endif
      default:  alu_y = bus_a + alu_b;
    endcase
  end

  // Load alignment: the addressed byte/half sits at the top of the big-endian read word.
  always_comb begin
    case (mem_size)
      SZ_BYTE: load_data = load_signed ? {{24{drData[31]}}, drData[31:24]}
                                       : {24'h0, drData[31:24]};
      SZ_HALF: load_data = load_signed ? {{16{drData[31]}}, drData[31:16]}
                                       : {16'h0, drData[31:16]};
      default: load_data = drData;
    endcase
  end

  // Write-back selection and destination register choice.
  always_comb begin
    pc_plus4 = iaddr + 32'd4;
    if (is_jal)      bus_w = pc_plus4;
    else if (mem_rd) bus_w = load_data;
    else             bus_w = alu_y;
    if (is_jal)       rf_waddr = 5'd31;
    else if (reg_dst) rf_waddr = rd;
    else              rf_waddr = rt;
    rf_we = reg_wr && !pcRst && (rf_waddr != 5'd0);
  end

  // Next-PC selection; a PC preset overrides every control-flow choice.
  always_comb begin
    br_target   = pc_plus4 + {imm_sext[29:0], 2'b00};
    jump_target = {pc_plus4[31:28], inst[25:0], 2'b00};
    started_d   = 1'b1;
    pc_d        = pc_plus4;
    if ((br_eq && (bus_a == bus_b)) || (br_ne && (bus_a != bus_b))) pc_d = br_target;
    if (is_jump) pc_d = jump_target;
    if (is_jr)   pc_d = bus_a;
    if (pcRst)   pc_d = pcIn;
  end

  // PC and start flag registers.
  always_ff @(posedge clk or negedge regRst) begin
    if (!regRst) begin
      pc_q      <= 32'h0;
      started_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      started_q <= started_d;
    end
  end

  // Register file write port; cleared as a whole by reset.
  always_ff @(posedge clk or negedge regRst) begin
    if (!regRst) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= 32'h0;
    end else if (rf_we) begin
      regs_q[rf_waddr] <= bus_w;
    end
  end

  assign daddr   = alu_y;
  assign dwData  = bus_b;
  assign dWr     = mem_wr && regRst && !pcRst;
  assign dSize   = mem_size;
  assign dRs     = rs;
  assign dRt     = rt;
  assign dRd     = rd;
  assign dRw     = rf_waddr;
  assign dimm16  = inst[15:0];
  assign dbusA   = bus_a;
  assign dbusB   = bus_b;
  assign dbusW   = bus_w;
  assign dregWr  = reg_wr && regRst;
  assign dregDst = reg_dst;
  assign djal    = is_jal;

endmodule

// File: tb/tb_scp_core.sv
// tb_scp_core: directed program for scp_core with a big-endian data memory model
// and a scoreboard queue of expected observations.
module tb_scp_core;

  logic               clk;
  logic               regRst;
  logic [31:0]        pcIn;
  logic               pcRst;
  logic [31:0]        iaddr;
  logic [31:0]        inst;
  logic [31:0]        daddr;
  logic [31:0]        drData;
  logic [31:0]        dwData;
  logic               dWr;
  logic [1:0]         dSize;
  logic [4:0]         dRt, dRs, dRd, dRw;
  logic signed [15:0] dimm16;
  logic [31:0]        dbusA, dbusB, dbusW;
  logic               dregWr, dregDst, djal;

  scp_core dut (
    .clk(clk), .regRst(regRst), .pcIn(pcIn), .pcRst(pcRst),
    .iaddr(iaddr), .inst(inst), .daddr(daddr), .drData(drData),
    .dwData(dwData), .dWr(dWr), .dSize(dSize),
    .dRt(dRt), .dRs(dRs), .dRd(dRd), .dRw(dRw), .dimm16(dimm16),
    .dbusA(dbusA), .dbusB(dbusB), .dbusW(dbusW),
    .dregWr(dregWr), .dregDst(dregDst), .djal(djal)
  );

  localparam int K_IADDR = 0, K_BUSW = 1, K_BUSA = 2, K_BUSB = 3, K_DWR = 4,
                 K_DSIZE = 5, K_REGWR = 6, K_REGDST = 7, K_JAL = 8, K_RW = 9,
                 K_DADDR = 10, K_DWDATA = 11, K_IMM = 12, K_RS = 13, K_RT = 14, K_RD = 15;

  localparam int OP_J = 2, OP_JAL = 3, OP_BEQ = 4, OP_BNE = 5, OP_ADDI = 8, OP_ADDIU = 9,
                 OP_SLTI = 10, OP_SLTIU = 11, OP_ANDI = 12, OP_ORI = 13, OP_XORI = 14,
                 OP_LUI = 15, OP_LB = 32, OP_LH = 33, OP_LW = 35, OP_LBU = 36, OP_LHU = 37,
                 OP_SB = 40, OP_SH = 41, OP_SW = 43;
  localparam int F_SLL = 0, F_JR = 8, F_ADD = 32, F_ADDU = 33, F_SUB = 34, F_AND = 36,
                 F_OR = 37, F_XOR = 38, F_NOR = 39, F_SLT = 42, F_SLTU = 43;

  typedef struct {
    int          kind;
    logic [31:0] val;
    string       tag;
  } exp_t;

  exp_t        sbq[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] pc;

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Data memory: 256 bytes, big-endian, combinational read, write on the rising edge.
  logic [7:0] dmem [256];
  logic [7:0] a0, a1, a2, a3;
  always_comb begin
    a0 = daddr[7:0];
    a1 = a0 + 8'd1;
    a2 = a0 + 8'd2;
    a3 = a0 + 8'd3;
    drData = {dmem[a0], dmem[a1], dmem[a2], dmem[a3]};
  end

  always @(posedge clk or negedge regRst) begin
    if (!regRst) begin
      for (int i = 0; i < 256; i++) dmem[i] <= 8'h00;
    end else if (dWr) begin
      case (dSize)
        2'b00: dmem[a0] <= dwData[7:0];
        2'b01: begin dmem[a0] <= dwData[15:8]; dmem[a1] <= dwData[7:0]; end
        default: begin
          dmem[a0] <= dwData[31:24]; dmem[a1] <= dwData[23:16];
          dmem[a2] <= dwData[15:8];  dmem[a3] <= dwData[7:0];
        end
      endcase
    end
  end

  function automatic logic [31:0] rType(input int rs, input int rt, input int rd,
                                        input int sh, input int fn);
    return {6'd0, rs[4:0], rt[4:0], rd[4:0], sh[4:0], fn[5:0]};
  endfunction

  function automatic logic [31:0] iType(input int op, input int rs, input int rt, input int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  function automatic logic [31:0] jType(input int op, input int target);
    return {op[5:0], target[25:0]};
  endfunction

  function automatic logic [31:0] observe(input int kind);
    case (kind)
      K_IADDR:  return iaddr;
      K_BUSW:   return dbusW;
      K_BUSA:   return dbusA;
      K_BUSB:   return dbusB;
      K_DWR:    return {31'h0, dWr};
      K_DSIZE:  return {30'h0, dSize};
      K_REGWR:  return {31'h0, dregWr};
      K_REGDST: return {31'h0, dregDst};
      K_JAL:    return {31'h0, djal};
      K_RW:     return {27'h0, dRw};
      K_DADDR:  return daddr;
      K_DWDATA: return dwData;
      K_IMM:    return {16'h0, dimm16};
      K_RS:     return {27'h0, dRs};
      K_RT:     return {27'h0, dRt};
      K_RD:     return {27'h0, dRd};
      default:  return 32'hxxxxxxxx;
    endcase
  endfunction

  task automatic pushExp(input int kind, input logic [31:0] val, input string tag);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    e.tag  = tag;
    sbq.push_back(e);
  endtask

  task automatic applyStimulus(input logic [31:0] word);
    inst = word;
    #1;
  endtask

  task automatic checkOutput();
    exp_t        e;
    logic [31:0] obs;
    while (sbq.size() > 0) begin
      e   = sbq.pop_front();
      obs = observe(e.kind);
      vectors++;
      assert (obs === e.val)
      else begin
        miscompares++;
        $error("[TB] FAIL %s: observed %h required %h", e.tag, obs, e.val);
      end
    end
  endtask

  // Compare the pending combinational expectations, clock once, then check the new PC.
  task automatic commit(input logic [31:0] nextPc, input string tag);
    checkOutput();
    @(posedge clk);
    #1;
    pushExp(K_IADDR, nextPc, tag);
    checkOutput();
    pc = nextPc;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    regRst = 1'b0;
    pcRst  = 1'b0;
    pcIn   = 32'h0000_1000;
    inst   = 32'h0;
    #2;

    // Reset: fetch address follows pcIn, no writes, registers read zero
    applyStimulus(iType(OP_SW, 1, 2, 0));
    pushExp(K_IADDR, 32'h1000, "reset iaddr");
    pushExp(K_DWR,   0, "reset dWr on sw");
    pushExp(K_BUSA,  0, "reset r1");
    pushExp(K_BUSB,  0, "reset r2");
    checkOutput();
    applyStimulus(rType(3, 4, 5, 0, F_ADD));
    pushExp(K_REGWR, 0, "reset dregWr on add");
    pushExp(K_BUSA,  0, "reset r3");
    checkOutput();
    @(negedge clk);
    regRst = 1'b1;
    inst   = 32'h0;
    pc     = 32'h1000;
    @(posedge clk);
    #1;
    pushExp(K_IADDR, 32'h1004, "first fetch advance");
    checkOutput();
    pc = 32'h1004;

    // Arithmetic chain
    applyStimulus(rType(2, 2, 2, 0, F_XOR));
    pushExp(K_BUSW, 0, "xor busW"); pushExp(K_REGDST, 1, "xor regDst");
    pushExp(K_RW, 2, "xor rw"); pushExp(K_REGWR, 1, "xor regWr");
    commit(pc + 4, "pc after xor");
    applyStimulus(iType(OP_ADDI, 2, 3, 9));
    pushExp(K_BUSW, 9, "addi r3 busW"); pushExp(K_REGDST, 0, "addi regDst");
    pushExp(K_RW, 3, "addi rw"); pushExp(K_IMM, 32'h9, "addi imm16");
    commit(pc + 4, "pc after addi r3");
    applyStimulus(iType(OP_ADDI, 3, 4, 6));
    pushExp(K_BUSA, 9, "r3 value"); pushExp(K_BUSW, 32'hF, "addi r4 busW");
    commit(pc + 4, "pc after addi r4");
    applyStimulus(rType(4, 2, 5, 0, F_ADD));
    pushExp(K_BUSA, 15, "r4 value"); pushExp(K_BUSB, 0, "r2 value");
    pushExp(K_BUSW, 15, "add r5 busW"); pushExp(K_REGDST, 1, "add regDst");
    pushExp(K_RW, 5, "add rw"); pushExp(K_RS, 4, "add rs");
    pushExp(K_RT, 2, "add rt"); pushExp(K_RD, 5, "add rd");
    commit(pc + 4, "pc after add");
    applyStimulus(rType(5, 0, 6, 0, F_OR));
    pushExp(K_BUSA, 15, "r5 value");
    commit(pc + 4, "pc after or");

    // Build 0x12345678 and exercise the data memory
    applyStimulus(iType(OP_LUI, 0, 3, 16'h1234));
    pushExp(K_BUSW, 32'h1234_0000, "lui busW");
    commit(pc + 4, "pc after lui");
    applyStimulus(iType(OP_ORI, 3, 3, 16'h5678));
    pushExp(K_BUSW, 32'h1234_5678, "ori busW");
    commit(pc + 4, "pc after ori");
    applyStimulus(iType(OP_SW, 0, 3, 0));
    pushExp(K_DWR, 1, "sw dWr"); pushExp(K_DSIZE, 3, "sw dSize");
    pushExp(K_DADDR, 0, "sw daddr"); pushExp(K_DWDATA, 32'h1234_5678, "sw dwData");
    pushExp(K_REGWR, 0, "sw regWr");
    commit(pc + 4, "pc after sw");
    applyStimulus(iType(OP_LW, 0, 7, 0));
    pushExp(K_BUSW, 32'h1234_5678, "lw busW"); pushExp(K_DWR, 0, "lw dWr");
    commit(pc + 4, "pc after lw");
    applyStimulus(iType(OP_LB, 0, 8, 0));
    pushExp(K_BUSW, 32'h12, "lb busW"); pushExp(K_DSIZE, 0, "lb dSize");
    commit(pc + 4, "pc after lb");
    applyStimulus(iType(OP_LBU, 0, 9, 0));
    pushExp(K_BUSW, 32'h12, "lbu busW");
    commit(pc + 4, "pc after lbu");
    applyStimulus(iType(OP_LH, 0, 10, 2));
    pushExp(K_BUSW, 32'h5678, "lh busW"); pushExp(K_DSIZE, 1, "lh dSize");
    pushExp(K_DADDR, 2, "lh daddr");
    commit(pc + 4, "pc after lh");
    applyStimulus(iType(OP_ADDI, 0, 11, 16'h80));
    pushExp(K_BUSW, 32'h80, "addi 0x80 busW");
    commit(pc + 4, "pc after addi r11");
    applyStimulus(iType(OP_SB, 0, 11, 1));
    pushExp(K_DWR, 1, "sb dWr"); pushExp(K_DSIZE, 0, "sb dSize");
    pushExp(K_DADDR, 1, "sb daddr");
    commit(pc + 4, "pc after sb");
    applyStimulus(iType(OP_LB, 0, 12, 1));
    pushExp(K_BUSW, 32'hFFFF_FF80, "lb negative busW");
    commit(pc + 4, "pc after lb neg");
    applyStimulus(iType(OP_LBU, 0, 13, 1));
    pushExp(K_BUSW, 32'h80, "lbu 0x80 busW");
    commit(pc + 4, "pc after lbu 0x80");
    applyStimulus(iType(OP_LW, 0, 7, 0));
    pushExp(K_BUSW, 32'h1280_5678, "lw after sb");
    commit(pc + 4, "pc after lw2");
    applyStimulus(iType(OP_ADDI, 0, 14, -2));
    pushExp(K_BUSW, 32'hFFFF_FFFE, "addi -2 busW"); pushExp(K_IMM, 32'hFFFE, "addi -2 imm16");
    commit(pc + 4, "pc after addi r14");
    applyStimulus(iType(OP_SH, 0, 14, 4));
    pushExp(K_DWR, 1, "sh dWr"); pushExp(K_DSIZE, 1, "sh dSize");
    commit(pc + 4, "pc after sh");
    applyStimulus(iType(OP_LHU, 0, 15, 4));
    pushExp(K_BUSW, 32'h0000_FFFE, "lhu busW");
    commit(pc + 4, "pc after lhu");
    applyStimulus(iType(OP_LH, 0, 16, 4));
    pushExp(K_BUSW, 32'hFFFF_FFFE, "lh neg busW");
    commit(pc + 4, "pc after lh neg");
    applyStimulus(iType(OP_LW, 0, 7, 4));
    pushExp(K_BUSW, 32'hFFFE_0000, "lw after sh");
    commit(pc + 4, "pc after lw3");

    // Remaining ALU operations
    applyStimulus(rType(2, 3, 17, 0, F_SUB));
    pushExp(K_BUSW, 32'hEDCB_A988, "sub busW");
    commit(pc + 4, "pc after sub");
    applyStimulus(rType(17, 0, 18, 0, F_SLT));
    pushExp(K_BUSW, 1, "slt busW");
    commit(pc + 4, "pc after slt");
    applyStimulus(rType(17, 0, 19, 0, F_SLTU));
    pushExp(K_BUSW, 0, "sltu busW");
    commit(pc + 4, "pc after sltu");
    applyStimulus(iType(OP_SLTI, 17, 20, 0));
    pushExp(K_BUSW, 1, "slti busW");
    commit(pc + 4, "pc after slti");
    applyStimulus(iType(OP_SLTIU, 0, 21, -1));
    pushExp(K_BUSW, 1, "sltiu busW");
    commit(pc + 4, "pc after sltiu");
    applyStimulus(iType(OP_ANDI, 3, 22, 16'hFF00));
    pushExp(K_BUSW, 32'h5600, "andi busW");
    commit(pc + 4, "pc after andi");
    applyStimulus(rType(0, 0, 23, 0, F_NOR));
    pushExp(K_BUSW, 32'hFFFF_FFFF, "nor busW");
    commit(pc + 4, "pc after nor");
    applyStimulus(iType(OP_XORI, 3, 24, 16'hFFFF));
    pushExp(K_BUSW, 32'h1234_A987, "xori busW");
    commit(pc + 4, "pc after xori");
    applyStimulus(rType(3, 17, 25, 0, F_ADDU));
    pushExp(K_BUSW, 0, "addu wrap busW");
    commit(pc + 4, "pc after addu");
    applyStimulus(rType(3, 22, 26, 0, F_AND));
    pushExp(K_BUSW, 32'h5600, "and busW");
    commit(pc + 4, "pc after and");
    applyStimulus(iType(OP_ADDIU, 0, 29, -1));
    pushExp(K_BUSW, 32'hFFFF_FFFF, "addiu busW");
    commit(pc + 4, "pc after addiu");

    // r0 ignores writes
    applyStimulus(iType(OP_ADDI, 0, 0, 5));
    pushExp(K_BUSW, 5, "addi r0 busW"); pushExp(K_RW, 0, "addi r0 rw");
    commit(pc + 4, "pc after addi r0");
    applyStimulus(rType(0, 0, 1, 0, F_ADD));
    pushExp(K_BUSA, 0, "r0 still zero");
    commit(pc + 4, "pc after add r1");

    // Shift encoding
    applyStimulus(rType(0, 3, 2, 4, F_SLL));
`ifdef SCP_SHIFT_EN
    pushExp(K_REGWR, 1, "sll regWr"); pushExp(K_BUSW, 32'h2345_6780, "sll busW");
`else
    pushExp(K_REGWR, 0, "sll nop regWr");
`endif
    commit(pc + 4, "pc after sll");
    applyStimulus(rType(2, 0, 26, 0, F_OR));
`ifdef SCP_SHIFT_EN
    pushExp(K_BUSA, 32'h2345_6780, "r2 after sll");
`else
    pushExp(K_BUSA, 0, "r2 unchanged after sll");
`endif
    commit(pc + 4, "pc after or r2");

    // Undefined encodings
    applyStimulus(iType(63, 0, 5, 16'h1234));
    pushExp(K_REGWR, 0, "undef op regWr"); pushExp(K_DWR, 0, "undef op dWr");
    commit(pc + 4, "pc after undef op");
    applyStimulus(rType(1, 2, 3, 0, 1));
    pushExp(K_REGWR, 0, "undef funct regWr");
    commit(pc + 4, "pc after undef funct");

    // PC preset: register file must not be written
    pcIn  = 32'h1000;
    pcRst = 1'b1;
    applyStimulus(iType(OP_ADDI, 0, 27, 7));
    commit(32'h1000, "pcRst preset");
    pcRst = 1'b0;

    // Branches
    applyStimulus(iType(OP_BEQ, 1, 1, 3));
    pushExp(K_REGWR, 0, "beq regWr");
    commit(32'h1010, "beq taken");
    applyStimulus(iType(OP_BNE, 1, 1, 5));
    commit(32'h1014, "bne not taken");
    applyStimulus(iType(OP_BNE, 3, 0, -2));
    commit(32'h1010, "bne taken backward");
    applyStimulus(rType(27, 0, 28, 0, F_OR));
    pushExp(K_BUSA, 0, "r27 untouched by pcRst");
    commit(32'h1014, "pc after or r27");
    applyStimulus(iType(OP_BEQ, 3, 0, 7));
    commit(32'h1018, "beq not taken");

    // Jumps
    pcRst = 1'b1;
    applyStimulus(32'h0);
    commit(32'h1000, "pcRst preset 2");
    pcRst = 1'b0;
    applyStimulus(jType(OP_JAL, 32'h800));
    pushExp(K_JAL, 1, "jal djal"); pushExp(K_RW, 31, "jal rw");
    pushExp(K_BUSW, 32'h1004, "jal busW"); pushExp(K_REGWR, 1, "jal regWr");
    commit(32'h2000, "jal target");
    applyStimulus(rType(31, 0, 0, 0, F_JR));
    pushExp(K_BUSA, 32'h1004, "r31 link"); pushExp(K_REGWR, 0, "jr regWr");
    pushExp(K_JAL, 0, "jr djal");
    commit(32'h1004, "jr return");
    applyStimulus(jType(OP_J, 32'hC00));
    pushExp(K_REGWR, 0, "j regWr");
    commit(32'h3000, "j target");

    // PC wrap
    pcIn  = 32'hFFFF_FFFC;
    pcRst = 1'b1;
    applyStimulus(32'h0);
    commit(32'hFFFF_FFFC, "pcRst to top");
    pcRst = 1'b0;
    applyStimulus(32'h0);
    commit(32'h0, "pc wrap");

    // Async reset with pcRst also high: reset dominates and clears registers
    regRst = 1'b0;
    pcRst  = 1'b1;
    pcIn   = 32'h1000;
    applyStimulus(rType(3, 4, 1, 0, F_ADD));
    pushExp(K_IADDR, 32'h1000, "re-reset iaddr");
    pushExp(K_BUSA, 0, "re-reset r3"); pushExp(K_BUSB, 0, "re-reset r4");
    pushExp(K_REGWR, 0, "re-reset regWr");
    checkOutput();
    @(negedge clk);
    regRst = 1'b1;
    pcRst  = 1'b0;
    inst   = 32'h0;
    @(posedge clk);
    #1;
    pushExp(K_IADDR, 32'h1004, "after re-reset");
    checkOutput();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
